// File: rtl/channel_fifo.sv
// Single-clock circular-buffer FIFO with show-ahead output and separate push/pop strobes.
// Optional sticky protocol-error flag (err port) is built only when CHANNEL_FIFO_ERR_EN is defined.
module channel_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chan_rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             write_valid,
  output logic             write_ready,
  input  logic             read_valid,
  output logic             read_ready,
  output logic [WIDTH-1:0] out_data
`ifdef CHANNEL_FIFO_ERR_EN
  ,
  output logic             err
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  // Handshake flags decode registered occupancy only, so a same-cycle pop never frees a slot.
  assign write_ready = (count != FULL_COUNT);
  assign read_ready  = (count != '0);
  assign push        = write_valid & write_ready;
  assign pop         = read_valid & read_ready;
  assign out_data    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !chan_rst) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (chan_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef CHANNEL_FIFO_ERR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (chan_rst) begin
      err <= 1'b0;
    end else if ((write_valid && !write_ready) || (read_valid && !read_ready)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_channel_fifo.sv
// Self-checking bench for channel_fifo: directed scenarios plus random traffic against a queue model.
// Checks err as well when CHANNEL_FIFO_ERR_EN is defined.
module tb_channel_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             chan_rst;
  logic [WIDTH-1:0] in_data;
  logic             write_valid;
  logic             write_ready;
  logic             read_valid;
  logic             read_ready;
  logic [WIDTH-1:0] out_data;
`ifdef CHANNEL_FIFO_ERR_EN
  logic             err;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [WIDTH-1:0] model [$];
  bit               err_model;

  channel_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .chan_rst    (chan_rst),
    .in_data     (in_data),
    .write_valid (write_valid),
    .write_ready (write_ready),
    .read_valid  (read_valid),
    .read_ready  (read_ready),
    .out_data    (out_data)
`ifdef CHANNEL_FIFO_ERR_EN
    ,
    .err         (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".read_ready"},  read_ready,  model.size() > 0);
    check({tag, ".write_ready"}, write_ready, model.size() < DEPTH);
    if (model.size() > 0) check({tag, ".out_data"}, out_data, model[0]);
`ifdef CHANNEL_FIFO_ERR_EN
    check({tag, ".err"}, err, err_model);
`endif
  endtask

  // One clock cycle: apply inputs, advance the queue model by the FIFO rules, then compare.
  task automatic step(input string tag, input logic wv, input logic [WIDTH-1:0] d,
                      input logic rv, input logic cr);
    bit can_push, can_pop;
    write_valid = wv;
    in_data     = d;
    read_valid  = rv;
    chan_rst    = cr;
    can_push = model.size() < DEPTH;
    can_pop  = model.size() > 0;
    @(posedge clk);
    if (cr) begin
      model.delete();
      err_model = 1'b0;
    end else begin
      if ((wv && !can_push) || (rv && !can_pop)) err_model = 1'b1;
      if (rv && can_pop) void'(model.pop_front());
      if (wv && can_push) model.push_back(d);
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic push(input string tag, input logic [WIDTH-1:0] d);
    step(tag, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic pop(input string tag);
    step(tag, 1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    longint unsigned sum;
    rst = 1'b0;
    chan_rst = 1'b0;
    write_valid = 1'b0;
    read_valid = 1'b0;
    in_data = '0;
    err_model = 1'b0;
    #12;
    check_outputs("reset");
    #5 rst = 1'b1;
    @(negedge clk);

    // Fill then drain in order.
    push("fill10", 10);
    push("fill20", 20);
    push("fill30", 30);
    push("fill40", 40);
    check("full_wr_ready", write_ready, 0);
    for (int i = 0; i < 4; i++) pop("drain");
    check("empty_rd_ready", read_ready, 0);

    // Summing consumer over four entries.
    for (int v = 1; v <= 4; v++) push("feed", v);
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      sum += out_data;
      pop("feed_pop");
    end
    check("reduce_sum", sum, 10);

    // Interleaved push/pop pairs wrap the pointers.
    for (int v = 1; v <= 6; v++) begin
      push("wrap_push", v);
      check("wrap_head", out_data, v);
      pop("wrap_pop");
      check("wrap_empty", read_ready, 0);
    end

    // Full with simultaneous push and pop: the push is dropped.
    for (int v = 1; v <= 4; v++) push("bnd_fill", v * 11);
    step("full_both", 1'b1, 99, 1'b1, 1'b0);
    check("full_both_count", model.size(), 3);
    for (int i = 0; i < 3; i++) pop("bnd_drain");
    check("bnd_empty", read_ready, 0);

    // Empty with simultaneous push and pop: the pop is ignored.
    step("empty_both", 1'b1, 7, 1'b1, 1'b0);
    check("empty_both_data", out_data, 7);
    pop("empty_both_pop");

    // Synchronous flush with three entries.
    for (int v = 1; v <= 3; v++) push("flush_fill", v + 100);
    step("flush", 1'b1, 55, 1'b1, 1'b1);
    check("flush_rd_ready", read_ready, 0);

    // Asynchronous reset between edges with two entries.
    push("arst_fill", 201);
    push("arst_fill", 202);
    #2 rst = 1'b0;
    #1;
    model.delete();
    err_model = 1'b0;
    check("arst_rd_ready", read_ready, 0);
    check("arst_wr_ready", write_ready, 1);
    #2 rst = 1'b1;
    push("after_arst", 303);
    check("after_arst_data", out_data, 303);
    pop("after_arst_pop");

`ifdef CHANNEL_FIFO_ERR_EN
    pop("err_set");
    check("err_set_flag", err, 1);
    step("err_hold", 1'b0, '0, 1'b0, 1'b0);
    check("err_hold_flag", err, 1);
    step("err_clear", 1'b0, '0, 1'b0, 1'b1);
    check("err_clear_flag", err, 0);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 31) == 0));
    end

    write_valid = 1'b0;
    read_valid = 1'b0;
    chan_rst = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
